// File: rtl/uart_row_command_loader_if.sv
// Byte-stream input from the UART receiver and the framebuffer write/status outputs
// of the row command loader, bundled so producer and consumer share one definition.
interface uart_row_command_loader_if #(
   parameter int ROW_ADDR_WIDTH = 5,
   parameter int COL_BYTE_WIDTH = 7
);
   logic [7:0]                               rx_data;
   logic                                     rx_data_ready;
   logic                                     ram_write_enable;
   logic [ROW_ADDR_WIDTH+COL_BYTE_WIDTH-1:0] ram_address;
   logic [7:0]                               ram_data;
   logic                                     row_loaded;
   logic [ROW_ADDR_WIDTH-1:0]                row_loaded_index;
   logic [7:0]                               brightness;
   logic                                     cmd_error;
   logic                                     busy;

   // The loader is the slave: it consumes bytes and drives the RAM port and status.
   modport slave (
      input  rx_data, rx_data_ready,
      output ram_write_enable, ram_address, ram_data, row_loaded,
             row_loaded_index, brightness, cmd_error, busy
   );

   modport master (
      output rx_data, rx_data_ready,
      input  ram_write_enable, ram_address, ram_data, row_loaded,
             row_loaded_index, brightness, cmd_error, busy
   );
endinterface

// File: rtl/uart_row_command_loader.sv
// Parses host bytes ('L' row loads, 'B' brightness) into framebuffer RAM writes,
// with an inter-byte timeout that abandons stalled commands.
module uart_row_command_loader #(
   parameter int                       PIXELS_PER_ROW = 64,
   parameter int                       COL_BYTE_WIDTH = 7,
   parameter int                       ROW_ADDR_WIDTH = 5,
   parameter int                       TIMEOUT_WIDTH  = 12,
   parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_TICKS  = 12'd4000
) (
   input  logic                     clk_in,
   input  logic                     reset,
   uart_row_command_loader_if.slave bus
);
   localparam logic [COL_BYTE_WIDTH-1:0] LAST_BYTE    = COL_BYTE_WIDTH'(2*PIXELS_PER_ROW-1);
   localparam logic [TIMEOUT_WIDTH-1:0]  TIMEOUT_LAST = TIMEOUT_TICKS - 1'b1;
   localparam int                        ADDR_W       = ROW_ADDR_WIDTH + COL_BYTE_WIDTH;

   typedef enum logic [1:0] {IDLE, ROW_ADDR, PIXELS, BRIGHT} state_t;

   state_t                    state_q,     state_d;
   logic [ROW_ADDR_WIDTH-1:0] row_q,       row_d;
   logic [COL_BYTE_WIDTH-1:0] byte_idx_q,  byte_idx_d;
   logic [TIMEOUT_WIDTH-1:0]  timer_q,     timer_d;
   logic                      wr_en_q,     wr_en_d;
   logic [ADDR_W-1:0]         wr_addr_q,   wr_addr_d;
   logic [7:0]                wr_data_q,   wr_data_d;
   logic                      row_done_q,  row_done_d;
   logic [ROW_ADDR_WIDTH-1:0] done_row_q,  done_row_d;
   logic [7:0]                bright_q,    bright_d;
   logic                      err_q,       err_d;
   logic                      busy_q,      busy_d;

   logic [7:0] rx;
   assign rx = bus.rx_data;

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      byte_idx_d = byte_idx_q;
      timer_d    = timer_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      row_done_d = 1'b0;
      done_row_d = done_row_q;
      bright_d   = bright_q;
      err_d      = 1'b0;

      // A strobe always takes priority over timeout expiry in the same cycle.
      if (bus.rx_data_ready) begin
         timer_d = '0;
         case (state_q)
            IDLE: begin
               if (rx == 8'h4C)      state_d = ROW_ADDR;
               else if (rx == 8'h42) state_d = BRIGHT;
               else                  err_d   = 1'b1;
            end
            ROW_ADDR: begin
               if (rx[7:ROW_ADDR_WIDTH] == '0) begin
                  row_d      = rx[ROW_ADDR_WIDTH-1:0];
                  byte_idx_d = '0;
                  state_d    = PIXELS;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
            PIXELS: begin
               wr_en_d   = 1'b1;
               wr_addr_d = {row_q, byte_idx_q};
               wr_data_d = rx;
               if (byte_idx_q == LAST_BYTE) begin
                  row_done_d = 1'b1;
                  done_row_d = row_q;
                  byte_idx_d = '0;
                  state_d    = IDLE;
               end else begin
                  byte_idx_d = byte_idx_q + 1'b1;
               end
            end
            BRIGHT: begin
               bright_d = rx;
               state_d  = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE) begin
         if (timer_q == TIMEOUT_LAST) begin
            err_d      = 1'b1;
            state_d    = IDLE;
            timer_d    = '0;
            byte_idx_d = '0;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         row_q      <= '0;
         byte_idx_q <= '0;
         timer_q    <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         row_done_q <= 1'b0;
         done_row_q <= '0;
         bright_q   <= 8'hFF;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         byte_idx_q <= byte_idx_d;
         timer_q    <= timer_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         row_done_q <= row_done_d;
         done_row_q <= done_row_d;
         bright_q   <= bright_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.ram_write_enable = wr_en_q;
   assign bus.ram_address      = wr_addr_q;
   assign bus.ram_data         = wr_data_q;
   assign bus.row_loaded       = row_done_q;
   assign bus.row_loaded_index = done_row_q;
   assign bus.brightness       = bright_q;
   assign bus.cmd_error        = err_q;
   assign bus.busy             = busy_q;
endmodule
